boot_loader: RTL and testbench

Serial-to-RAM program loader sitting directly upstream of the Memory block. It consumes a byte stream (header plus payload), assembles 16-bit words and writes each one into RAM through the shared 16-bit bus. It drives `address` and `load_bar` exactly as the CPU would, after winning the bus through a request/grant handshake. It lets a program be loaded into RAM (address ≥ 256) without CPU involvement; ROM (address < 256) is never written.

---
 rtl/boot_loader_pkg.sv | 39 +++
 rtl/boot_loader_word_assembler.sv | 54 +++++
 rtl/boot_loader.sv | 241 ++++++++++++++++++++++++
 tb/tb_boot_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared types and constants for the serial-to-RAM loader.
//   state_e          - loader FSM state encoding
//   RAM_BASE_DEFAULT - lowest writable RAM address (ROM sits below it)
//   HDR_BYTES, WORD_BYTES, CSUM_BYTES - byte counts of the stream fields
//   HOLD_W           - width of the write-strobe hold counter (HOLD_CYCLES <= 15)
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN adds the CSUM state.
package boot_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_REQ,
    S_WRITE,
`ifdef BOOT_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [15:0] RAM_BASE_DEFAULT = 16'h0100;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 2;
  localparam int CSUM_BYTES = 1;

  localparam int HOLD_W = 4;

  // Running mod-256 stream checksum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/boot_loader_word_assembler.sv
// word_assembler: pairs incoming bytes (high byte first) into 16-bit words.
// Ports:
//   clk, reset_bar   - clock, asynchronous active-low reset
//   clr              - restart pairing at a high byte (pulsed at load start)
//   accept           - the FSM wants a byte this cycle; becomes rx_ready
//   rx_data/rx_valid - byte stream in
//   rx_ready         - handshake back to the byte source
//   byte_fire        - a byte is transferred this cycle
//   word             - {latched high byte, current byte}; meaningful with word_valid
//   word_valid       - the low byte of a pair is transferred this cycle
module word_assembler
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_bar,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        byte_fire,
  output logic [15:0] word,
  output logic        word_valid
);

  logic       lo_q, lo_d;
  logic [7:0] hi_q, hi_d;

  always_comb begin
    rx_ready   = accept;
    byte_fire  = rx_valid & accept;
    word       = {hi_q, rx_data};
    word_valid = byte_fire & lo_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    if (clr) begin
      lo_d = 1'b0;
    end else if (byte_fire) begin
      lo_d = ~lo_q;
      if (!lo_q) hi_d = rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      lo_q <= 1'b0;
      hi_q <= 8'h00;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: consumes a header+payload byte stream and writes each 16-bit
// word into RAM over the shared bus after a request/grant handshake.
// Stream: addr_hi, addr_lo, len_hi, len_lo, len x (data_hi, data_lo)
//         [, checksum byte when BOOT_LOADER_CHECKSUM_EN is defined].
// Parameters: RAM_BASE (lowest writable address), HOLD_CYCLES (1..15 cycles
//             of load_bar low per write).
// Ports:
//   clk, reset_bar      - clock, asynchronous active-low reset
//   start               - begin a load when idle
//   rx_data/valid/ready - byte stream handshake
//   bus_req/bus_grant   - bus ownership handshake
//   address, bus_out    - write address and data
//   bus_oe, load_bar    - bus drive enable, active-low RAM write strobe
//   busy, done, err     - status; done/err are sticky until the next start
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [15:0] RAM_BASE    = RAM_BASE_DEFAULT,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_bar,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [15:0] address,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  output logic        load_bar,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CYCLES);

  // Where a load goes once all words are written.
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_e S_END = S_CSUM;
`else
  localparam state_e S_END = S_DONE;
`endif

  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       remain_q, remain_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        asm_clr;
  logic        asm_accept;
  logic        byte_fire;
  logic        word_valid;
  logic [15:0] word;
  logic [15:0] addr_inc;

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset_bar  (reset_bar),
    .clr        (asm_clr),
    .accept     (asm_accept),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .byte_fire  (byte_fire),
    .word       (word),
    .word_valid (word_valid)
  );

  assign addr_inc = addr_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    remain_d   = remain_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    asm_clr    = 1'b0;
    asm_accept = 1'b0;
    bus_req    = 1'b0;
    bus_oe     = 1'b0;
    load_bar   = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          asm_clr = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = S_ADDR_HI;
        end
      end
      S_ADDR_HI: begin
        asm_accept = 1'b1;
        if (byte_fire) state_d = S_ADDR_LO;
      end
      S_ADDR_LO: begin
        asm_accept = 1'b1;
        if (word_valid) begin
          addr_d  = word;
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        asm_accept = 1'b1;
        if (byte_fire) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        asm_accept = 1'b1;
        if (word_valid) begin
          remain_d = word;
          if (addr_q < RAM_BASE)  state_d = S_ERR;
          else if (word == 16'd0) state_d = S_END;
          else                    state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        asm_accept = 1'b1;
        if (byte_fire) state_d = S_DATA_LO;
      end
      S_DATA_LO: begin
        asm_accept = 1'b1;
        if (word_valid) begin
          data_d  = word;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          hold_d  = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (hold_q < HOLD_LIM) begin
          // Strobe phase: strobe and drive are gated by grant so that losing
          // the bus releases it within the same cycle.
          bus_req = 1'b1;
          if (bus_grant) begin
            bus_oe   = 1'b1;
            load_bar = 1'b0;
            hold_d   = hold_q + 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          // Release cycle: strobe is high but address/data are still held so
          // Memory sees hold time after load_bar rises.
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            addr_d  = addr_inc;
            state_d = S_END;
          end else if (addr_inc < RAM_BASE) begin
            state_d = S_ERR;
          end else begin
            addr_d  = addr_inc;
            state_d = S_DATA_HI;
          end
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CSUM: begin
        asm_accept = 1'b1;
        if (byte_fire) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Every header and payload byte feeds the checksum; the checksum byte
    // itself does not.
    if (byte_fire && state_q != S_CSUM) csum_d = csum_add(csum_q, rx_data);
`endif
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q  <= S_IDLE;
      addr_q   <= 16'h0000;
      data_q   <= 16'h0000;
      remain_q <= 16'h0000;
      hold_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum_q   <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      remain_q <= remain_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign address = addr_q;
  assign bus_out = data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed loads from the test plan plus randomized
// loads, all scored against a word-level model of which RAM writes a stream
// should produce and how the load should end.
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int          HOLD = 2;
  localparam logic [15:0] RB   = 16'h0100;

  logic        clk = 1'b0;
  logic        reset_bar = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        bus_req;
  logic        bus_grant = 1'b0;
  logic [15:0] address;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        load_bar;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  boot_loader #(.RAM_BASE(RB), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .address   (address),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .load_bar  (load_bar),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 0);
    check({tag, "_bus_req"},  bus_req,  0);
    check({tag, "_bus_oe"},   bus_oe,   0);
    check({tag, "_load_bar"}, load_bar, 1);
    check({tag, "_address"},  address,  0);
    check({tag, "_bus_out"},  bus_out,  0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
    check({tag, "_err"},      err,      0);
  endtask

  // Memory-side observer: records each completed strobe pulse.
  int          lo_run = 0;
  logic [15:0] cur_a, cur_d;
  logic [15:0] obs_a[$];
  logic [15:0] obs_d[$];
  int          obs_h[$];

  always @(negedge clk) begin
    if (!reset_bar) begin
      lo_run = 0;
    end else begin
      check("oe_vs_load_bar", bus_oe, !load_bar);
      if (!load_bar) begin
        check("strobe_needs_grant", bus_grant, 1);
        if (lo_run > 0) begin
          check("addr_stable", address, cur_a);
          check("data_stable", bus_out, cur_d);
        end
        lo_run++;
        cur_a = address;
        cur_d = bus_out;
      end else if (lo_run > 0) begin
        check("addr_hold", address, cur_a);
        check("data_hold", bus_out, cur_d);
        obs_a.push_back(cur_a);
        obs_d.push_back(cur_d);
        obs_h.push_back(lo_run);
        lo_run = 0;
      end
    end
  end

  logic [15:0] wq[$];
  logic [7:0]  bytes[$];

  // Reference: words land at consecutive addresses while the target is RAM;
  // the first target in ROM (start below RB, or a wrap) aborts the load.
  task automatic model(input logic [15:0] a0, input int len, input bit csum_bad,
                       output bit e_err, output int n_wr, output int n_bytes);
    n_wr  = 0;
    e_err = 0;
    if (a0 < RB) begin
      e_err   = 1;
      n_bytes = HDR_BYTES;
      return;
    end
    for (int i = 0; i < len; i++) begin
      logic [15:0] a;
      a = a0 + 16'(i);
      if (a < RB) begin
        e_err = 1;
        break;
      end
      n_wr++;
    end
    n_bytes = HDR_BYTES + WORD_BYTES * n_wr;
`ifdef BOOT_LOADER_CHECKSUM_EN
    if (!e_err) begin
      n_bytes += CSUM_BYTES;
      e_err = csum_bad;
    end
`endif
  endtask

  // mode 0: normal, 1: drop grant on the first strobe cycle, 2: reset on strobe.
  task automatic run_load(input logic [15:0] a0, input int len, input bit csum_bad,
                          input int gdelay, input bit gaps, input int mode);
    logic [15:0] l;
    logic [7:0]  sum;
    bit          e_err, fire, finished;
    int          n_wr, n_bytes, consumed, gcnt, dropped, n;
    l = 16'(len);
    bytes.delete();
    bytes.push_back(a0[15:8]);
    bytes.push_back(a0[7:0]);
    bytes.push_back(l[15:8]);
    bytes.push_back(l[7:0]);
    for (int i = 0; i < len; i++) begin
      bytes.push_back(wq[i][15:8]);
      bytes.push_back(wq[i][7:0]);
    end
    sum = 8'h00;
    foreach (bytes[i]) sum = sum + bytes[i];
`ifdef BOOT_LOADER_CHECKSUM_EN
    bytes.push_back(sum + 8'(csum_bad));
`endif
    model(a0, len, csum_bad, e_err, n_wr, n_bytes);
    obs_a.delete(); obs_d.delete(); obs_h.delete();

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    consumed = 0; gcnt = 0; dropped = 0; finished = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      fire = rx_valid && rx_ready;
      if (dropped == 1) begin
        check("drop_load_bar", load_bar, 1);
        check("drop_bus_oe", bus_oe, 0);
        dropped = 2;
      end
      if (mode == 2 && !load_bar) begin
        #1 reset_bar = 1'b0;
        #1 check_reset_outputs("async_reset");
        rx_valid  = 1'b0;
        bus_grant = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_bar = 1'b1;
        return;
      end
      if (!busy) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
      if (fire) begin
        void'(bytes.pop_front());
        consumed++;
      end
      rx_valid = (bytes.size() > 0) && (!gaps || $urandom_range(0, 2) != 0);
      rx_data  = (bytes.size() > 0) ? bytes[0] : 8'h00;
      // A start while a write is pending must be ignored.
      start = bus_req && ($urandom_range(0, 7) == 0);
      if (mode == 1 && dropped == 0 && bus_grant && !load_bar) begin
        bus_grant = 1'b0;
        dropped   = 1;
      end else if (dropped == 0) begin
        if (bus_req) begin
          if (gcnt >= gdelay) bus_grant = 1'b1;
          else begin
            gcnt++;
            bus_grant = 1'b0;
          end
        end else begin
          bus_grant = 1'b0;
          gcnt      = 0;
        end
      end
    end
    start     = 1'b0;
    rx_valid  = 1'b0;
    bus_grant = 1'b0;
    check("load_finished", finished, 1);
    if (mode == 1) begin
      check("drop_err", err, 1);
      check("drop_done", done, 0);
      check("drop_writes", obs_a.size(), 0);
      return;
    end
    check("done", done, !e_err);
    check("err", err, e_err);
    check("bytes_consumed", consumed, n_bytes);
    check("write_count", obs_a.size(), n_wr);
    n = (obs_a.size() < n_wr) ? obs_a.size() : n_wr;
    for (int i = 0; i < n; i++) begin
      check("write_addr", obs_a[i], a0 + 16'(i));
      check("write_data", obs_d[i], wq[i]);
      check("hold_cycles", obs_h[i], HOLD);
    end
  endtask

  initial begin
    int len, sel;
    logic [15:0] a;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    reset_bar = 1'b1;

    wq = '{16'h1234, 16'hABCD};
    run_load(16'h0100, 2, 0, 0, 0, 0);
    wq = '{16'h5555};
    run_load(16'h00F0, 1, 0, 0, 0, 0);
    wq = '{16'h1111, 16'h2222};
    run_load(16'hFFFF, 2, 0, 0, 0, 0);
    wq = '{16'hBEEF};
    run_load(16'h0200, 1, 0, 10, 0, 1);
    wq.delete();
    run_load(16'h0400, 0, 0, 0, 0, 0);
`ifdef BOOT_LOADER_CHECKSUM_EN
    wq = '{16'h1234, 16'hABCD};
    run_load(16'h0300, 2, 1, 0, 0, 0);
`endif
    wq = '{16'hCAFE, 16'hF00D, 16'h0BAD};
    run_load(16'h0500, 3, 0, 2, 0, 2);
    run_load(16'h0500, 3, 0, 1, 0, 0);

    for (int it = 0; it < 20; it++) begin
      len = $urandom_range(0, 6);
      sel = $urandom_range(0, 5);
      if (sel == 0)      a = 16'($urandom_range(0, 16'h00FF));
      else if (sel == 1) a = 16'hFFFF - 16'($urandom_range(0, 4));
      else               a = 16'($urandom_range(16'h0100, 16'hFFF0));
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back(16'($urandom));
      run_load(a, len, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
